// File: rtl/fetch_redirect_unit_pkg.sv
// Shared types and defaults for the IF-stage fetch redirect unit.
package fetch_redirect_unit_pkg;

  localparam int unsigned DefaultBitsAddr     = 11;
  localparam int unsigned DefaultCiclosFlush  = 2;
  localparam int unsigned DefaultBitsContador = 2;
  localparam int unsigned ResetPc             = 0;

  typedef enum logic [1:0] {
    StRun    = 2'd0,
    StFlush  = 2'd1,
    StHalted = 2'd2
  } fru_state_e;

endpackage

// File: rtl/fetch_redirect_unit_if.sv
// Signal bundle between the ID-stage resolver/hazard logic and the fetch redirect unit.
// Optional statistics ports appear when FETCH_REDIRECT_STATS_EN is defined.
interface fetch_redirect_unit_if
  import fetch_redirect_unit_pkg::*;
#(
  parameter int unsigned CANT_BITS_ADDR = DefaultBitsAddr
);
  logic                      i_enable_etapa;
  logic                      i_stall;
  logic                      i_branch_control;
  logic [CANT_BITS_ADDR-1:0] i_branch_dir;
  logic                      i_halt;
  logic [CANT_BITS_ADDR-1:0] o_pc;
  logic [CANT_BITS_ADDR-1:0] o_adder_pc;
  logic                      o_flush_if_id;
  logic                      o_redirect_pending;
  logic                      o_halted;
`ifdef FETCH_REDIRECT_STATS_EN
  logic [15:0]               o_cant_saltos;
  logic [15:0]               o_cant_burbujas;
`endif

  modport master (
    output i_enable_etapa, i_stall, i_branch_control, i_branch_dir, i_halt,
`ifdef FETCH_REDIRECT_STATS_EN
    input  o_cant_saltos, o_cant_burbujas,
`endif
    input  o_pc, o_adder_pc, o_flush_if_id, o_redirect_pending, o_halted
  );

  modport slave (
    input  i_enable_etapa, i_stall, i_branch_control, i_branch_dir, i_halt,
`ifdef FETCH_REDIRECT_STATS_EN
    output o_cant_saltos, o_cant_burbujas,
`endif
    output o_pc, o_adder_pc, o_flush_if_id, o_redirect_pending, o_halted
  );
endinterface

// File: rtl/fetch_redirect_unit_pc_register.sv
// Program counter register: synchronous reset, stage enable, load and increment.
module fetch_redirect_unit_pc_register
  import fetch_redirect_unit_pkg::*;
#(
  parameter int unsigned Width = DefaultBitsAddr
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             load_i,
  input  logic             inc_i,
  input  logic [Width-1:0] load_val_i,
  output logic [Width-1:0] pc_o,
  output logic [Width-1:0] pc_plus1_o
);

  logic [Width-1:0] pc_q;

  // Natural Width-bit wrap gives the silent roll-over to zero.
  assign pc_plus1_o = pc_q + Width'(1);
  assign pc_o       = pc_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q <= Width'(ResetPc);
    end else if (en_i) begin
      if (load_i) begin
        pc_q <= load_val_i;
      end else if (inc_i) begin
        pc_q <= pc_plus1_o;
      end
    end
  end

endmodule

// File: rtl/fetch_redirect_unit.sv
// IF-stage PC owner: sequential fetch, stall hold, taken-branch redirect with flush bubbles, halt.
// Define FETCH_REDIRECT_STATS_EN to add saturating redirect/bubble counters.
module fetch_redirect_unit
  import fetch_redirect_unit_pkg::*;
#(
  parameter int unsigned CANT_BITS_ADDR     = DefaultBitsAddr,
  parameter int unsigned CANT_CICLOS_FLUSH  = DefaultCiclosFlush,
  parameter int unsigned CANT_BITS_CONTADOR = DefaultBitsContador
) (
  input logic                  i_clock,
  input logic                  i_reset,
  fetch_redirect_unit_if.slave bus
);

  localparam logic [CANT_BITS_CONTADOR-1:0] FlushInit = CANT_BITS_CONTADOR'(CANT_CICLOS_FLUSH - 1);

  fru_state_e                  state_q, state_d;
  logic [CANT_BITS_CONTADOR-1:0] cnt_q, cnt_d;
  logic                        pend_vld_q, pend_vld_d;
  logic [CANT_BITS_ADDR-1:0]   pend_dir_q, pend_dir_d;
  logic                        flush_q;
  logic                        pc_load, pc_inc;
  logic [CANT_BITS_ADDR-1:0]   pc_load_val;

  fetch_redirect_unit_pc_register #(
    .Width (CANT_BITS_ADDR)
  ) u_pc_register (
    .clk_i      (i_clock),
    .rst_i      (i_reset),
    .en_i       (bus.i_enable_etapa),
    .load_i     (pc_load),
    .inc_i      (pc_inc),
    .load_val_i (pc_load_val),
    .pc_o       (bus.o_pc),
    .pc_plus1_o (bus.o_adder_pc)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pend_vld_d  = pend_vld_q;
    pend_dir_d  = pend_dir_q;
    pc_load     = 1'b0;
    pc_inc      = 1'b0;
    pc_load_val = pend_dir_q;
    unique case (state_q)
      StRun: begin
        if (bus.i_stall) begin
          // Redirect seen under stall is parked; the latest one wins.
          if (bus.i_branch_control) begin
            pend_vld_d = 1'b1;
            pend_dir_d = bus.i_branch_dir;
          end
        end else if (bus.i_branch_control || pend_vld_q) begin
          // Redirect beats a same-cycle halt: that halt sits on the wrong path.
          pc_load     = 1'b1;
          pc_load_val = bus.i_branch_control ? bus.i_branch_dir : pend_dir_q;
          pend_vld_d  = 1'b0;
          cnt_d       = FlushInit;
          state_d     = StFlush;
        end else if (bus.i_halt) begin
          state_d = StHalted;
        end else begin
          pc_inc = 1'b1;
        end
      end
      StFlush: begin
        pc_inc = 1'b1;
        if (cnt_q == '0) begin
          state_d = StRun;
        end else begin
          cnt_d = cnt_q - CANT_BITS_CONTADOR'(1);
        end
      end
      StHalted: begin
        state_d = StHalted;
      end
      default: begin
        state_d = StRun;
      end
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q    <= StRun;
      cnt_q      <= '0;
      pend_vld_q <= 1'b0;
      pend_dir_q <= '0;
      flush_q    <= 1'b0;
    end else if (bus.i_enable_etapa) begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pend_vld_q <= pend_vld_d;
      pend_dir_q <= pend_dir_d;
      flush_q    <= (state_d == StFlush);
    end
  end

  assign bus.o_flush_if_id      = flush_q;
  assign bus.o_redirect_pending = pend_vld_q;
  assign bus.o_halted           = (state_q == StHalted);

`ifdef FETCH_REDIRECT_STATS_EN
  logic [15:0] saltos_q, burbujas_q;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      saltos_q   <= '0;
      burbujas_q <= '0;
    end else if (bus.i_enable_etapa) begin
      if (pc_load && (saltos_q != 16'hFFFF)) begin
        saltos_q <= saltos_q + 16'd1;
      end
      if ((state_d == StFlush) && (burbujas_q != 16'hFFFF)) begin
        burbujas_q <= burbujas_q + 16'd1;
      end
    end
  end

  assign bus.o_cant_saltos   = saltos_q;
  assign bus.o_cant_burbujas = burbujas_q;
`endif

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Scoreboard bench for fetch_redirect_unit: directed scenarios followed by random traffic.
module tb_fetch_redirect_unit;

  localparam int unsigned AW    = 11;
  localparam int          FLUSH = 2;
  localparam int          PCMOD = 1 << AW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_redirect_unit_if #(.CANT_BITS_ADDR(AW)) bus ();

  fetch_redirect_unit #(
    .CANT_BITS_ADDR     (AW),
    .CANT_CICLOS_FLUSH  (FLUSH),
    .CANT_BITS_CONTADOR (2)
  ) dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  typedef struct {
    int pc;
    int adder;
    int flush;
    int pend;
    int halted;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  // Reference model: fetch address, bubbles still owed, parked redirect, halted flag.
  int m_pc       = 0;
  int m_left     = 0;
  int m_pend     = 0;
  int m_pend_dir = 0;
  int m_halted   = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input bit r, input bit en, input bit stall, input bit br,
                     input int dir, input bit halt);
    exp_t e;
    @(negedge clk);
    rst                  = r;
    bus.i_enable_etapa   = en;
    bus.i_stall          = stall;
    bus.i_branch_control = br;
    bus.i_branch_dir     = AW'(dir);
    bus.i_halt           = halt;
    if (r) begin
      m_pc = 0; m_left = 0; m_pend = 0; m_pend_dir = 0; m_halted = 0;
    end else if (en && !m_halted) begin
      if (m_left > 0) begin
        m_pc = (m_pc + 1) % PCMOD;
        m_left--;
      end else if (stall) begin
        if (br) begin
          m_pend = 1;
          m_pend_dir = dir % PCMOD;
        end
      end else if (br || m_pend) begin
        m_pc   = br ? (dir % PCMOD) : m_pend_dir;
        m_pend = 0;
        m_left = FLUSH;
      end else if (halt) begin
        m_halted = 1;
      end else begin
        m_pc = (m_pc + 1) % PCMOD;
      end
    end
    e.pc     = m_pc;
    e.adder  = (m_pc + 1) % PCMOD;
    e.flush  = (m_left > 0) ? 1 : 0;
    e.pend   = m_pend;
    e.halted = m_halted;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 1, 0, 0, 0, 0);
  endtask

  // Monitor: one expected record per clock edge, compared shortly after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("pc",       int'(bus.o_pc),               e.pc);
        check("adder_pc", int'(bus.o_adder_pc),         e.adder);
        check("flush",    int'(bus.o_flush_if_id),      e.flush);
        check("pending",  int'(bus.o_redirect_pending), e.pend);
        check("halted",   int'(bus.o_halted),           e.halted);
      end
    end
  end

  initial begin
    bus.i_enable_etapa   = 1'b1;
    bus.i_stall          = 1'b0;
    bus.i_branch_control = 1'b0;
    bus.i_branch_dir     = '0;
    bus.i_halt           = 1'b0;

    cyc(1, 1, 0, 0, 0, 0);
    idle(7);                                   // 1..7
    cyc(0, 1, 0, 1, 'h040, 0);                 // redirect at PC=7
    idle(3);
    cyc(0, 1, 1, 1, 'h100, 0);                 // redirect under stall -> pending
    cyc(0, 1, 1, 0, 0, 0);
    cyc(0, 1, 1, 0, 0, 0);
    idle(4);                                   // pending applied, two bubbles
    cyc(0, 1, 1, 1, 'h222, 0);                 // last-wins overwrite while pending
    cyc(0, 1, 1, 1, 'h333, 0);
    idle(4);
    cyc(0, 1, 0, 1, 'h7FD, 0);                 // reach 0x7FF then wrap
    idle(4);
    cyc(0, 1, 0, 1, 'h010, 1);                 // halt with redirect: redirect wins
    idle(3);                                   // PC now 0x013
    cyc(0, 1, 1, 0, 0, 1);                     // halt under stall ignored
    cyc(0, 1, 0, 0, 0, 1);                     // halt at 0x013
    cyc(0, 1, 0, 1, 'h055, 0);
    cyc(0, 1, 1, 1, 'h066, 1);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0);                     // reset exits halted
    idle(2);
    cyc(0, 1, 0, 1, 'h200, 0);                 // freeze mid-flush
    cyc(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 'h300, 0);
    cyc(0, 1, 0, 1, 'h300, 0);                 // last bubble, redirect ignored
    idle(2);
    cyc(0, 1, 0, 1, 'h123, 0);                 // reset mid-flush
    cyc(1, 1, 0, 0, 0, 0);
    cyc(0, 1, 1, 1, 'h456, 0);                 // reset mid-pending
    cyc(1, 1, 0, 0, 0, 0);
    idle(1);

    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 39) == 0),
          ($urandom_range(0, 7) != 0),
          ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 5) == 0),
          int'($urandom_range(0, PCMOD - 1)),
          ($urandom_range(0, 24) == 0));
    end

    for (int i = 0; i < 10 && sb.size() != 0; i++) begin
      @(posedge clk);
      #3;
    end
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d records left, expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_redirect_unit.md
Name: fetch_redirect_unit

Overview:
- IF-stage consumer of the ID-stage branch resolver outputs (branch taken flag plus target address).
- Owns the program counter and applies sequential increment, stall hold, taken-branch redirect and halt.
- Generates the IF/ID flush bubbles that cost two cycles per taken branch; a not-taken branch costs zero cycles.
- Feeds PC+1 back to the ID stage for branch target addition.

Parameters:
- CANT_BITS_ADDR, 11, PC / instruction memory address width (word addressed, PC steps by 1).
- CANT_CICLOS_FLUSH, 2, number of IF/ID bubble cycles after a taken redirect (legal range 1..3).
- CANT_BITS_CONTADOR, 2, width of the internal flush counter; must hold CANT_CICLOS_FLUSH.

Ports:
- i_clock  input  1  system clock, rising edge.
- i_reset  input  1  synchronous, active-high reset.
- i_enable_etapa  input  1  stage enable (debug step); low = full freeze of all state.
- i_stall  input  1  hazard-unit stall; holds PC.
- i_branch_control  input  1  taken redirect request from ID.
- i_branch_dir  input  CANT_BITS_ADDR  redirect target.
- i_halt  input  1  halt opcode decoded in IF.
- o_pc  output  CANT_BITS_ADDR  current fetch address (registered).
- o_adder_pc  output  CANT_BITS_ADDR  o_pc+1, combinational, modulo 2^CANT_BITS_ADDR.
- o_flush_if_id  output  1  insert bubble into IF/ID this cycle (registered).
- o_redirect_pending  output  1  redirect captured during stall, not yet applied.
- o_halted  output  1  processor halted.

Behaviour:
- Reset values (synchronous, active-high): o_pc=0, o_flush_if_id=0, o_redirect_pending=0, o_halted=0, FSM=RUN, counter=0.
- Reset has priority over every other input, including when asserted mid-flush or mid-pending.
- Reset exits HALTED.
- i_enable_etapa=0: all registers hold, including the counter and pending register. i_branch_control is ignored and not captured.
- FSM states: RUN, FLUSH, HALTED. All transitions below apply only when enabled.
- RUN, i_branch_control=1, i_stall=0:
  - PC <= i_branch_dir on the next edge.
  - FSM -> FLUSH, counter <= CANT_CICLOS_FLUSH-1.
  - o_flush_if_id=1 from the next cycle.
- RUN, i_branch_control=1, i_stall=1:
  - Target is latched into the pending register; o_redirect_pending=1; PC holds.
  - On the first enabled cycle with i_stall=0, the pending target is applied exactly as a fresh redirect and pending clears.
  - A new i_branch_control during pending overwrites the target (last wins).
- RUN, i_stall=1, no redirect: PC holds; o_flush_if_id=0.
- RUN, normal: PC <= o_adder_pc. Wrap-around from 2^CANT_BITS_ADDR-1 to 0 is silent.
- FLUSH:
  - o_flush_if_id=1.
  - PC increments from the target (i_stall is ignored; bubbles carry no hazards).
  - i_branch_control and i_halt are ignored (wrong path).
  - Counter decrements each cycle; when counter=0, FSM -> RUN next cycle.
  - Total flush-high cycles = CANT_CICLOS_FLUSH.
- RUN, i_halt=1, i_stall=0, i_branch_control=0: FSM -> HALTED, PC frozen at the halt address.
- Same-cycle i_halt and i_branch_control: redirect wins and halt is discarded, because the halt is on the wrong path.
- i_halt while stalled: ignored until the stall drops.
- HALTED: o_halted=1; PC holds; o_flush_if_id=0; all inputs except i_reset are ignored.
- Latency: redirect request at edge N gives o_pc=target after edge N; o_flush_if_id high for cycles N+1..N+CANT_CICLOS_FLUSH.

Optional Feature:
- Macro FETCH_REDIRECT_STATS_EN.
- Defined: adds outputs o_cant_saltos (16-bit count of applied redirects) and o_cant_burbujas (16-bit count of flush cycles).
  - Both counters saturate at 0xFFFF, clear on reset and hold while i_enable_etapa=0.
- Undefined: these ports and counters are absent; the rest of the behaviour is identical.

Decomposition:
- Shared package holds:
  - FSM state encoding: RUN=2'd0, FLUSH=2'd1, HALTED=2'd2.
  - Default CANT_BITS_ADDR.
  - Reset PC constant (0).
- One sub-module: pc_register (enable/load/increment register with synchronous reset). The top holds the FSM, pending register and counters.

Test Plan:
- Reset, then 5 enabled cycles with no events -> o_pc = 0,1,2,3,4,5; o_flush_if_id=0 throughout.
- At PC=7, pulse i_branch_control with i_branch_dir=0x040 -> o_pc=0x040, then 0x041, 0x042; o_flush_if_id=1 for exactly 2 cycles; FSM returns to RUN.
- i_stall=1 with i_branch_control, dir=0x100, held 3 cycles -> PC holds and o_redirect_pending=1. Stall drops -> o_pc=0x100 next cycle, pending=0, 2 flush cycles follow.
- PC=0x7FF, no events -> o_pc=0x000; o_adder_pc=0x001.
- i_halt and i_branch_control (dir=0x010) in the same cycle -> redirect applied, o_halted=0. Later a lone i_halt at PC=0x013 -> o_halted=1, PC frozen at 0x013; i_reset pulse -> PC=0, o_halted=0.
- Mid-FLUSH: i_enable_etapa=0 for 4 cycles -> PC, flush and counter frozen. Re-enable -> the remaining flush cycle completes. Any i_branch_control during FLUSH is ignored.
